// File: rtl/axi_burst_mem.sv
// AXI-style burst memory slave: INCR write and read bursts with per-beat range
// checking; the read and write channels run independently over one word array.
module axi_burst_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int AW1   = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] LO = {1'b0, BASE_ADDR};
  localparam logic [AW1-1:0] HI = LO + (AW1'(DEPTH_WORDS) << OFF_W);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // One extra address bit so a burst running past the top of the address space
  // lands out of range instead of wrapping back into the array.
  function automatic logic [AW1-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] start,
                                               input logic [7:0] n);
    return {1'b0, start} + (AW1'(n) << OFF_W);
  endfunction

  function automatic logic in_range(input logic [AW1-1:0] a);
    return (a >= LO) && (a < HI);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AW1-1:0] a);
    return IDX_W'((a - LO) >> OFF_W);
  endfunction

  logic rst_done;

  always_ff @(posedge aclk) begin
    rst_done <= aresetn;
  end

  // ---------------- write channel ----------------
  w_state_t              w_state, w_next;
  logic [ADDR_WIDTH-1:0] w_start;
  logic [7:0]            w_len, w_cnt;
  logic                  w_err;
  logic [AW1-1:0]        w_addr;
  logic                  w_in, w_fire, w_final, beat_err;

  assign w_addr   = beat_addr(w_start, w_cnt);
  assign w_in     = in_range(w_addr);
  assign w_fire   = (w_state == W_DATA) && wvalid;
  assign w_final  = w_fire && (w_cnt == w_len);
  assign beat_err = !w_in || (wlast != (w_cnt == w_len));

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = rst_done;
        if (awvalid && rst_done) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && (w_cnt == w_len)) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      w_start <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      bresp   <= '0;
    end else begin
      w_state <= w_next;
      if (awvalid && awready) begin
        w_start <= awaddr;
        w_len   <= awlen;
        w_cnt   <= '0;
        w_err   <= 1'b0;
      end
      if (w_fire) begin
        w_cnt <= w_cnt + 8'd1;
        w_err <= w_err | beat_err;
        if (w_final) bresp <= (w_err | beat_err) ? 2'b10 : 2'b00;
      end
      if (bvalid && bready) bresp <= '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (aresetn && w_fire && w_in) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_start, sel_start;
  logic [7:0]            r_len, r_cnt, sel_cnt, sel_len;
  logic [AW1-1:0]        r_addr;
  logic                  r_in, ld_first, ld_next;

  // The next beat is fetched while the current one is being accepted, so the
  // address source switches between the AR channel and the captured burst.
  assign sel_start = (r_state == R_IDLE) ? araddr : r_start;
  assign sel_cnt   = (r_state == R_IDLE) ? 8'd0 : r_cnt + 8'd1;
  assign sel_len   = (r_state == R_IDLE) ? arlen : r_len;
  assign r_addr    = beat_addr(sel_start, sel_cnt);
  assign r_in      = in_range(r_addr);
  assign ld_first  = (r_state == R_IDLE) && arvalid && rst_done;
  assign ld_next   = (r_state == R_DATA) && rready && !rlast;

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = rst_done;
        if (arvalid && rst_done) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      r_start <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      rdata   <= '0;
      rresp   <= '0;
      rlast   <= 1'b0;
    end else begin
      r_state <= r_next;
      if (ld_first) begin
        r_start <= araddr;
        r_len   <= arlen;
      end
      if (ld_first || ld_next) begin
        r_cnt <= sel_cnt;
        rdata <= r_in ? mem[word_idx(r_addr)] : '0;
        rresp <= r_in ? 2'b00 : 2'b10;
        rlast <= (sel_cnt == sel_len);
      end else if (rvalid && rready && rlast) begin
        rlast <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_mem.sv
// Directed self-checking bench for axi_burst_mem (default parameters).
module tb_axi_burst_mem;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] awaddr, araddr, wdata;
  logic [7:0]  awlen, arlen;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [31:0] rdata;

  int vectors = 0;
  int errs    = 0;

  logic [31:0] wexp [256];
  logic [31:0] rexp_data [256];
  logic [1:0]  rexp_resp [256];

  always #5 aclk = ~aclk;

  axi_burst_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] len);
    int n = 0;
    awaddr = a; awlen = len; awvalid = 1'b1;
    while (!awready && n < 100) begin @(negedge aclk); n++; end
    if (n >= 100) chk("aw_timeout", awready, 1);
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] len);
    int n = 0;
    araddr = a; arlen = len; arvalid = 1'b1;
    while (!arready && n < 100) begin @(negedge aclk); n++; end
    if (n >= 100) chk("ar_timeout", arready, 1);
    @(negedge aclk);
    arvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    while (!wready && n < 100) begin @(negedge aclk); n++; end
    if (n >= 100) chk("w_timeout", wready, 1);
    @(negedge aclk);
  endtask

  task automatic b_check(input logic [1:0] exp, input string tag);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 100) begin @(negedge aclk); n++; end
    chk({tag, "_bvalid"}, bvalid, 1);
    chk({tag, "_bresp"}, bresp, exp);
    @(negedge aclk);
    bready = 1'b0;
    chk({tag, "_bdone"}, bvalid, 0);
  endtask

  task automatic wr_burst(input logic [31:0] a, input int len, input logic [3:0] s,
                          input int last_beat, input logic [1:0] exp, input string tag);
    aw_send(a, 8'(len));
    for (int i = 0; i <= len; i++) w_send(wexp[i], s, i == last_beat);
    wvalid = 1'b0; wlast = 1'b0;
    b_check(exp, tag);
  endtask

  task automatic rd_burst(input logic [31:0] a, input int len, input string tag);
    rready = 1'b1;
    ar_send(a, 8'(len));
    for (int i = 0; i <= len; i++) begin
      chk({tag, "_rvalid"}, rvalid, 1);
      chk({tag, "_rdata"}, rdata, rexp_data[i]);
      chk({tag, "_rresp"}, rresp, rexp_resp[i]);
      chk({tag, "_rlast"}, rlast, i == len);
      @(negedge aclk);
    end
    chk({tag, "_rend"}, rvalid, 0);
    rready = 1'b0;
  endtask

  task automatic ok_resp();
    for (int i = 0; i < 256; i++) rexp_resp[i] = 2'b00;
  endtask

  initial begin
    aresetn = 1'b0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;

    // reset values
    repeat (3) @(negedge aclk);
    chk("rst_awready", awready, 0); chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);   chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);   chk("rst_rlast", rlast, 0);
    chk("rst_bresp", bresp, 0);     chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_awready", awready, 1); chk("post_arready", arready, 1);

    // basic 4-beat burst
    wexp[0] = 32'h11; wexp[1] = 32'h22; wexp[2] = 32'h33; wexp[3] = 32'h44;
    wr_burst(32'h0, 3, 4'hF, 3, 2'b00, "basic_w");
    ok_resp();
    for (int i = 0; i < 4; i++) rexp_data[i] = wexp[i];
    rd_burst(32'h0, 3, "basic_r");

    // byte strobes
    wexp[0] = 32'hAABBCCDD;
    wr_burst(32'h10, 0, 4'hF, 0, 2'b00, "strb_w1");
    wexp[0] = 32'h000000EE;
    wr_burst(32'h10, 0, 4'h1, 0, 2'b00, "strb_w2");
    rexp_data[0] = 32'hAABBCCEE;
    rd_burst(32'h10, 0, "strb_r");

    // burst crossing the top of the array
    wexp[0] = 32'h1; wexp[1] = 32'h2; wexp[2] = 32'h3; wexp[3] = 32'h4;
    wr_burst(32'hFF8, 3, 4'hF, 3, 2'b10, "oob_w");
    rexp_data[0] = 32'h1; rexp_data[1] = 32'h2; rexp_data[2] = '0; rexp_data[3] = '0;
    rexp_resp[2] = 2'b10; rexp_resp[3] = 2'b10;
    rd_burst(32'hFF8, 3, "oob_r");
    ok_resp();
    rexp_data[0] = 32'h11;
    rd_burst(32'h0, 0, "oob_nowrap");

    // early wlast
    wexp[0] = 32'h5; wexp[1] = 32'h6; wexp[2] = 32'h7;
    wr_burst(32'h20, 2, 4'hF, 1, 2'b10, "wlast_w");
    for (int i = 0; i < 3; i++) rexp_data[i] = wexp[i];
    rd_burst(32'h20, 2, "wlast_r");

    // 256-beat burst
    for (int i = 0; i < 256; i++) begin
      wexp[i] = 32'h1000 + 32'(i);
      rexp_data[i] = wexp[i];
    end
    wr_burst(32'h400, 255, 4'hF, 255, 2'b00, "long_w");
    rd_burst(32'h400, 255, "long_r");

    // B stalled while a read with toggling rready runs alongside
    begin
      int n = 0;
      int b = 0;
      aw_send(32'h40, 8'd0);
      w_send(32'h55, 4'hF, 1'b1);
      wvalid = 1'b0; wlast = 1'b0;
      while (!bvalid && n < 100) begin @(negedge aclk); n++; end
      rready = 1'b0;
      ar_send(32'h400, 8'd7);
      for (int k = 0; k < 15; k++) begin
        chk("stall_bvalid", bvalid, 1);
        chk("stall_bresp", bresp, 0);
        chk("stall_rvalid", rvalid, 1);
        chk("stall_rdata", rdata, 32'h1000 + 32'(b));
        chk("stall_rlast", rlast, b == 7);
        rready = (k % 2 == 0);
        @(negedge aclk);
        if (rready) b++;
      end
      rready = 1'b0;
      chk("stall_rend", rvalid, 0);
      b_check(2'b00, "stall_b");
      rexp_data[0] = 32'h55;
      rd_burst(32'h40, 0, "stall_r");
    end

    // reset in the middle of a write burst
    for (int i = 0; i < 4; i++) wexp[i] = 32'hB1 + 32'(i);
    wr_burst(32'h80, 3, 4'hF, 3, 2'b00, "pre_w");
    aw_send(32'h80, 8'd3);
    w_send(32'hA1, 4'hF, 1'b0);
    w_send(32'hA2, 4'hF, 1'b0);
    wvalid = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    chk("mid_rst_awready", awready, 0);
    chk("mid_rst_wready", wready, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("mid_post_awready", awready, 1);
    chk("mid_post_bvalid", bvalid, 0);
    chk("mid_post_wready", wready, 0);
    rexp_data[0] = 32'hA1; rexp_data[1] = 32'hA2;
    rexp_data[2] = 32'hB3; rexp_data[3] = 32'hB4;
    rd_burst(32'h80, 3, "mid_r");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
